// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two cache memory ports, the shared slow_memory
// port and the sticky error flags seen by the bench.
//   slave  modport : used by mem_arbiter (takes cache requests and memory
//                    replies, drives memory requests and cache replies)
//   master modport : used by the environment (caches + slow_memory + bench)
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    // I-cache port
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    // D-cache port
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    // shared slow_memory port
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    // sticky error flags
    logic              proto_err;
    logic              timeout_err;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output proto_err, timeout_err
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  proto_err, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow_memory between the I-cache and D-cache ports.
// One port is granted at a time; its request is passed straight through to
// memory and mem_ready is routed back only to that port. Flags read+write on
// one port (proto_err) and grants that wait TIMEOUT cycles (timeout_err).
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave: cache ports, memory port, error flags
module mem_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int TIMEOUT      = 64,
    parameter int FIXED_PRIO_D = 0
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t            state, state_nxt;
    logic              last_d, last_d_nxt;   // 1: last completed grant was D
    logic [CNT_W-1:0]  wait_cnt;
    logic              proto_q, timeout_q;
    logic              req_i, req_d;
    logic              g_read, g_write;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    assign req_i = bus.i_read | bus.i_write;
    assign req_d = bus.d_read | bus.d_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        g_read     = 1'b0;
        g_write    = 1'b0;
        g_addr     = '0;
        g_wdata    = '0;
        case (state)
            IDLE: begin
                if (req_i && req_d)
                    state_nxt = (FIXED_PRIO_D != 0 || !last_d) ? GRANT_D : GRANT_I;
                else if (req_i)
                    state_nxt = GRANT_I;
                else if (req_d)
                    state_nxt = GRANT_D;
            end
            GRANT_I: begin
                g_read  = bus.i_read;
                g_write = bus.i_write;
                g_addr  = bus.i_addr;
                g_wdata = bus.i_wdata;
                if (bus.mem_ready) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b0;
                end else if (!req_i) begin
                    state_nxt  = IDLE;   // cache withdrew; abandon quietly
                end
            end
            GRANT_D: begin
                g_read  = bus.d_read;
                g_write = bus.d_write;
                g_addr  = bus.d_addr;
                g_wdata = bus.d_wdata;
                if (bus.mem_ready) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b1;
                end else if (!req_d) begin
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter is zero during the first grant cycle because IDLE clears it;
    // timeout_err rises on the same edge the counter reaches TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            proto_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE)
                wait_cnt <= '0;
            else if (!bus.mem_ready && wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (state != IDLE && !bus.mem_ready && wait_cnt == CNT_MAX - 1'b1)
                timeout_q <= 1'b1;
            if ((bus.i_read & bus.i_write) | (bus.d_read & bus.d_write))
                proto_q <= 1'b1;
        end
    end

    // write wins when a port asserts both
    assign bus.mem_read    = g_read & ~g_write;
    assign bus.mem_write   = g_write;
    assign bus.mem_addr    = g_addr;
    assign bus.mem_wdata   = g_wdata;
    assign bus.i_rdata     = bus.mem_rdata;
    assign bus.d_rdata     = bus.mem_rdata;
    assign bus.i_ready     = bus.mem_ready & (state == GRANT_I);
    assign bus.d_ready     = bus.mem_ready & (state == GRANT_D);
    assign bus.proto_err   = proto_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is round-robin, instance 1 is fixed D
// priority. Tests push expected memory requests and cache replies into
// queues; a memory model and a reply monitor pop and compare them.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    typedef struct packed { logic [1:0] port; logic [DW-1:0] rdata; } rsp_t;
    typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mreq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // stimulus [inst][port 0=I,1=D]
    logic          rd_s [2][2];
    logic          wr_s [2][2];
    logic [AW-1:0] ad_s [2][2];
    logic [DW-1:0] wd_s [2][2];
    logic          mrdy [2];
    logic [DW-1:0] mrd  [2];
    // observed
    logic          rdy_w  [2][2];
    logic [DW-1:0] rdat_w [2][2];
    logic          mrd_w [2];
    logic          mwr_w [2];
    logic [AW-1:0] mad_w [2];
    logic [DW-1:0] mwd_w [2];
    logic          perr_w [2];
    logic          terr_w [2];

    for (genvar g = 0; g < 2; g++) begin : u
        mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(64), .FIXED_PRIO_D(g)) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );
        assign bus.i_read    = rd_s[g][0];
        assign bus.i_write   = wr_s[g][0];
        assign bus.i_addr    = ad_s[g][0];
        assign bus.i_wdata   = wd_s[g][0];
        assign bus.d_read    = rd_s[g][1];
        assign bus.d_write   = wr_s[g][1];
        assign bus.d_addr    = ad_s[g][1];
        assign bus.d_wdata   = wd_s[g][1];
        assign bus.mem_ready = mrdy[g];
        assign bus.mem_rdata = mrd[g];
        assign rdy_w[g][0]   = bus.i_ready;
        assign rdy_w[g][1]   = bus.d_ready;
        assign rdat_w[g][0]  = bus.i_rdata;
        assign rdat_w[g][1]  = bus.d_rdata;
        assign mrd_w[g]      = bus.mem_read;
        assign mwr_w[g]      = bus.mem_write;
        assign mad_w[g]      = bus.mem_addr;
        assign mwd_w[g]      = bus.mem_wdata;
        assign perr_w[g]     = bus.proto_err;
        assign terr_w[g]     = bus.timeout_err;
    end

    int    total = 0;
    int    bad   = 0;
    rsp_t  rsp_q [2][$];
    mreq_t mq    [2][$];
    int    lat   [2];
    bit    stray [2];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_mem(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] w);
        mreq_t m;
        m.wr = wr; m.addr = a; m.wdata = w;
        mq[k].push_back(m);
    endtask

    task automatic push_rsp(input int k, input int p, input logic [DW-1:0] r);
        rsp_t e;
        e.port = 2'(p); e.rdata = r;
        rsp_q[k].push_back(e);
    endtask

    // Raise a request, hold it until the port's ready, then drop it.
    task automatic req(input int k, input int p, input bit sync, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] w);
        bit seen = 0;
        if (sync) begin @(posedge clk); #1; end
        rd_s[k][p] = rd; wr_s[k][p] = wr; ad_s[k][p] = a; wd_s[k][p] = w;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk); #2;
            if (rdy_w[k][p]) seen = 1;
        end
        chk("ready_seen", seen, 1);
        @(posedge clk); #1;
        rd_s[k][p] = 0; wr_s[k][p] = 0;
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk({tag, "_mem_read"},  mrd_w[k],  0);
        chk({tag, "_mem_write"}, mwr_w[k],  0);
        chk({tag, "_mem_addr"},  mad_w[k],  0);
        chk({tag, "_mem_wdata"}, mwd_w[k],  0);
        chk({tag, "_i_ready"},   rdy_w[k][0], 0);
        chk({tag, "_d_ready"},   rdy_w[k][1], 0);
        chk({tag, "_proto_err"}, perr_w[k], 0);
        chk({tag, "_timeout"},   terr_w[k], 0);
    endtask

    // slow_memory model: replies lat[k] grant cycles after a new request,
    // with rdata = {4{4'hA, addr}}; checks each new request against mq.
    bit busy [2];
    int mcnt [2];
    initial begin
        mreq_t m;
        for (int k = 0; k < 2; k++) begin
            mrdy[k] = 0; mrd[k] = '0; busy[k] = 0; mcnt[k] = 0; stray[k] = 0; lat[k] = 5;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mrdy[k]) begin
                    mrdy[k] = 0; busy[k] = 0;
                end else if (stray[k]) begin
                    mrdy[k] = 1; mrd[k] = {4{32'h5A5A5A5A}}; stray[k] = 0;
                end else if (mrd_w[k] | mwr_w[k]) begin
                    if (!busy[k]) begin
                        busy[k] = 1; mcnt[k] = 0;
                        if (mq[k].size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_mem_req inst=%0d addr=%h expected none", k, mad_w[k]);
                        end else begin
                            m = mq[k].pop_front();
                            chk("mem_write", mwr_w[k], m.wr);
                            chk("mem_read",  mrd_w[k], !m.wr);
                            chk("mem_addr",  mad_w[k], m.addr);
                            if (m.wr) chk("mem_wdata", mwd_w[k], m.wdata);
                        end
                    end
                    mcnt[k]++;
                    if (mcnt[k] >= lat[k]) begin
                        mrdy[k] = 1; mrd[k] = {4{4'hA, mad_w[k]}};
                    end
                end else begin
                    busy[k] = 0;
                end
            end
        end
    end

    // reply monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk); #2;
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++)
                    if (rdy_w[k][p]) begin
                        if (rsp_q[k].size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_ready inst=%0d port=%0d got 1 expected 0", k, p);
                        end else begin
                            r = rsp_q[k].pop_front();
                            chk("ready_port", 128'(p), 128'(r.port));
                            chk("rdata", rdat_w[k][p], r.rdata);
                        end
                    end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [DW-1:0] WD1 = 128'hDEADBEEF_00000000_00000000_00000001;
    localparam logic [DW-1:0] WD2 = 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0;

    initial begin
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                rd_s[k][p] = 0; wr_s[k][p] = 0; ad_s[k][p] = '0; wd_s[k][p] = '0;
            end
        #3;
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        @(posedge clk); #1; rst = 0;

        // I-only read, request reaches memory one cycle later
        push_mem(0, 0, 28'h0000010, '0);
        push_rsp(0, 0, 128'hA0000010_A0000010_A0000010_A0000010);
        fork
            req(0, 0, 1, 1, 0, 28'h0000010, '0);
            begin
                @(posedge clk); #1;
                @(negedge clk); #2; chk("t1_idle_mem_read", mrd_w[0], 0);
                @(negedge clk); #2; chk("t1_mem_read", mrd_w[0], 1);
                chk("t1_mem_addr", mad_w[0], 28'h0000010);
            end
        join

        // simultaneous I and D, round-robin, last grant was I -> D then I
        push_mem(0, 0, 28'h0000100, '0);
        push_rsp(0, 1, 128'hA0000100_A0000100_A0000100_A0000100);
        push_mem(0, 0, 28'h0000200, '0);
        push_rsp(0, 0, 128'hA0000200_A0000200_A0000200_A0000200);
        fork
            req(0, 1, 1, 1, 0, 28'h0000100, '0);
            req(0, 0, 1, 1, 0, 28'h0000200, '0);
        join

        // fixed D priority, D keeps requesting -> D,D,D,I
        push_mem(1, 0, 28'h0000300, '0);
        push_rsp(1, 1, 128'hA0000300_A0000300_A0000300_A0000300);
        push_mem(1, 0, 28'h0000310, '0);
        push_rsp(1, 1, 128'hA0000310_A0000310_A0000310_A0000310);
        push_mem(1, 0, 28'h0000320, '0);
        push_rsp(1, 1, 128'hA0000320_A0000320_A0000320_A0000320);
        push_mem(1, 0, 28'h0000400, '0);
        push_rsp(1, 0, 128'hA0000400_A0000400_A0000400_A0000400);
        fork
            begin
                req(1, 1, 1, 1, 0, 28'h0000300, '0);
                req(1, 1, 0, 1, 0, 28'h0000310, '0);
                req(1, 1, 0, 1, 0, 28'h0000320, '0);
            end
            req(1, 0, 1, 1, 0, 28'h0000400, '0);
        join

        // D write
        push_mem(0, 1, 28'h0000020, WD1);
        push_rsp(0, 1, 128'hA0000020_A0000020_A0000020_A0000020);
        req(0, 1, 1, 0, 1, 28'h0000020, WD1);
        chk("t4_proto_err", perr_w[0], 0);

        // request dropped mid-grant: no ready, next request served normally
        lat[0] = 100;
        push_mem(0, 0, 28'h0000060, '0);
        @(posedge clk); #1; rd_s[0][0] = 1; ad_s[0][0] = 28'h0000060;
        repeat (4) @(posedge clk);
        #1; rd_s[0][0] = 0;
        @(negedge clk); #2; chk("drop_mem_read", mrd_w[0], 0);
        lat[0] = 5;
        push_mem(0, 0, 28'h0000070, '0);
        push_rsp(0, 1, 128'hA0000070_A0000070_A0000070_A0000070);
        req(0, 1, 1, 1, 0, 28'h0000070, '0);

        // stray mem_ready in IDLE produces no ready
        @(posedge clk); #1; stray[0] = 1;
        @(negedge clk); #2;
        chk("stray_i_ready", rdy_w[0][0], 0);
        chk("stray_d_ready", rdy_w[0][1], 0);
        repeat (2) @(posedge clk);

        // read+write together -> proto_err from next cycle, write forwarded
        push_mem(0, 1, 28'h0000030, WD2);
        push_rsp(0, 1, 128'hA0000030_A0000030_A0000030_A0000030);
        fork
            req(0, 1, 1, 1, 1, 28'h0000030, WD2);
            begin
                @(posedge clk); #1;
                @(negedge clk); #2; chk("proto_before", perr_w[0], 0);
                @(negedge clk); #2; chk("proto_after", perr_w[0], 1);
            end
        join
        chk("proto_sticky", perr_w[0], 1);
        chk("proto_other_inst", perr_w[1], 0);

        // timeout: counter is n in grant cycle n (0 = entry cycle)
        lat[0] = 70;
        push_mem(0, 0, 28'h0000040, '0);
        push_rsp(0, 0, 128'hA0000040_A0000040_A0000040_A0000040);
        fork
            req(0, 0, 1, 1, 0, 28'h0000040, '0);
            begin
                bit got = 0;
                @(posedge clk); #1;
                for (int c = 0; c < 10 && !got; c++) begin
                    @(negedge clk); #2;
                    if (mrd_w[0]) got = 1;
                end
                chk("to_grant_seen", got, 1);
                repeat (63) @(negedge clk);
                #2; chk("to_cycle63", terr_w[0], 0);
                @(negedge clk); #2; chk("to_cycle64", terr_w[0], 1);
            end
        join
        chk("to_sticky", terr_w[0], 1);
        lat[0] = 5;

        // reset mid-grant
        lat[0] = 100;
        push_mem(0, 0, 28'h0000050, '0);
        @(posedge clk); #1; rd_s[0][0] = 1; ad_s[0][0] = 28'h0000050;
        repeat (3) @(negedge clk);
        #2; chk("rg_granted", mrd_w[0], 1);
        #1; rst = 1;
        #1; chk_zero(0, "rst_mid");
        rd_s[0][0] = 0;
        @(posedge clk); #1; rst = 0;
        repeat (3) @(posedge clk);

        for (int k = 0; k < 2; k++) begin
            chk("rsp_q_empty", rsp_q[k].size(), 0);
            chk("mq_empty", mq[k].size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
